// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM tone generator and the note sequencer that
// feeds it: default widths, the post-reset PWM top, waveform select encodings
// and the phase increment that denotes a rest (muted) note.
// ---------------------------------------------------------------------------
package pwm_pkg;

  // Default NCO accumulator / phase increment width.
  localparam int PWM_PHASE_WIDTH = 32;

  // Default PWM counter / top width.
  localparam int PWM_TOP_WIDTH = 8;

  // PWM top after reset (period = top + 1 clocks).
  localparam logic [7:0] PWM_RESET_TOP = 8'hff;

  // The waveform is 8 bits wide and is built from the top 9 phase bits.
  localparam int WAVE_WIDTH      = 8;
  localparam int WAVE_PHASE_BITS = 9;

  // Waveform select encodings; code 3 is reserved and plays as square.
  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_RSVD   = 2'd3
  } wave_sel_t;

  // Phase increment of a rest note: the accumulator is cleared and the
  // output is muted from the next PWM period.
  localparam logic [31:0] PHASE_DELTA_REST = 32'd0;

endpackage

// File: rtl/pwm_wave_shaper.sv
// ---------------------------------------------------------------------------
// pwm_wave_shaper
// Turns the top phase bits of the NCO into an 8-bit waveform sample,
// registered (one clock of latency).
//
// Optional feature macro: PWM_TONE_TRIANGLE_EN
//   defined   : wave_sel == WAVE_TRI produces a triangle
//   undefined : no triangle logic; WAVE_TRI plays as square
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   phase_msbs  in   phase[MSB -: 9]
//   wave_sel    in   waveform select (pwm_pkg::wave_sel_t encoding)
//   wave        out  registered waveform sample, 0..255
// ---------------------------------------------------------------------------
module pwm_wave_shaper
  import pwm_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WAVE_PHASE_BITS-1:0] phase_msbs,
  input  logic [1:0]                 wave_sel,
  output logic [WAVE_WIDTH-1:0]      wave
);

  logic [WAVE_WIDTH-1:0] shaped;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  // Square is the default: it covers the reserved code and, in builds
  // without the triangle, the triangle code as well.
  always_comb begin
    shaped = {WAVE_WIDTH{phase_msbs[WAVE_PHASE_BITS-1]}};
    case (wave_sel)
      WAVE_SAW: shaped = phase_msbs[WAVE_PHASE_BITS-1:1];
`ifdef PWM_TONE_TRIANGLE_EN
      // First half of the cycle ramps up on phase[30:23], second half
      // mirrors it back down.
      WAVE_TRI: shaped = phase_msbs[WAVE_PHASE_BITS-1] ? ~phase_msbs[WAVE_WIDTH-1:0]
                                                       :  phase_msbs[WAVE_WIDTH-1:0];
`endif
      default: ;
    endcase
  end

`ifndef PWM_TONE_TRIANGLE_EN
  // Only the triangle needs the lowest of the nine phase bits.
  logic unused_phase_lsb;
  assign unused_phase_lsb = phase_msbs[0];
`endif

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave <= '0;
    end else begin
      wave <= shaped;
    end
  end

endmodule

// File: rtl/pwm_tone_generator.sv
// ---------------------------------------------------------------------------
// pwm_tone_generator
// NCO tone generator with PWM audio output. A 32-bit phase accumulator
// advances by i_phase_delta every clock (25 MHz sample rate); the shaped
// waveform is scaled to the current PWM period once per period and drives a
// single-bit PWM pin.
//
// Optional feature macro: PWM_TONE_TRIANGLE_EN (triangle waveform on
// i_wave_sel == 2; otherwise that code plays as square).
//
// Ports:
//   i_clk           in   system clock, 25 MHz
//   i_rst           in   synchronous reset, active-high
//   i_phase_delta   in   NCO increment per clock; 0 = rest (mute)
//   i_top           in   requested PWM top; period = top + 1 clocks
//   i_top_valid     in   i_top may be adopted at the next period boundary
//   i_wave_sel      in   0 square, 1 saw, 2 triangle, 3 reserved (square)
//   o_pwm           out  registered PWM output
//   o_period_start  out  high during count 0 of every PWM period
//   o_duty          out  duty currently applied
// ---------------------------------------------------------------------------
module pwm_tone_generator
  import pwm_pkg::*;
#(
  parameter int                   PHASE_WIDTH = PWM_PHASE_WIDTH,
  parameter int                   TOP_WIDTH   = PWM_TOP_WIDTH,
  parameter logic [TOP_WIDTH-1:0] RESET_TOP   = PWM_RESET_TOP
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [PHASE_WIDTH-1:0] i_phase_delta,
  input  logic [TOP_WIDTH-1:0]   i_top,
  input  logic                   i_top_valid,
  input  logic [1:0]             i_wave_sel,
  output logic                   o_pwm,
  output logic                   o_period_start,
  output logic [TOP_WIDTH-1:0]   o_duty
);

  localparam int PROD_WIDTH = WAVE_WIDTH + TOP_WIDTH + 1;

  logic [PHASE_WIDTH-1:0] r_phase;
  logic [TOP_WIDTH-1:0]   r_count;
  logic [TOP_WIDTH-1:0]   r_top;
  logic [WAVE_WIDTH-1:0]  r_wave;
  logic                   muted;

  logic                   rest;
  logic                   wrap;
  logic [TOP_WIDTH-1:0]   count_next;
  logic [TOP_WIDTH-1:0]   new_top;
  logic [TOP_WIDTH:0]     top_plus1;
  logic [PROD_WIDTH-1:0]  product;
  logic [TOP_WIDTH-1:0]   duty_next;

  assign rest = (i_phase_delta == PHASE_WIDTH'(PHASE_DELTA_REST));

  // Last clock of the current period; top, duty and mute change only here,
  // so a period already running is never shortened.
  assign wrap       = (r_count == r_top);
  assign count_next = wrap ? '0 : r_count + TOP_WIDTH'(1);
  assign new_top    = i_top_valid ? i_top : r_top;

  // duty = (wave * (top + 1)) >> 8, always within 0..top because wave < 256.
  assign top_plus1 = {1'b0, new_top} + {{TOP_WIDTH{1'b0}}, 1'b1};
  assign product   = {{(TOP_WIDTH + 1){1'b0}}, r_wave}
                   * {{WAVE_WIDTH{1'b0}}, top_plus1};
  assign duty_next = product[TOP_WIDTH+WAVE_WIDTH-1:WAVE_WIDTH];

  // The product MSB is always zero and the fraction bits are discarded.
  logic unused_product_bits;
  assign unused_product_bits = ^{product[PROD_WIDTH-1], product[WAVE_WIDTH-1:0]};

  pwm_wave_shaper u_wave_shaper (
    .clk        (i_clk),
    .rst        (i_rst),
    .phase_msbs (r_phase[PHASE_WIDTH-1 -: WAVE_PHASE_BITS]),
    .wave_sel   (i_wave_sel),
    .wave       (r_wave)
  );

  // A rest clears the accumulator so the next note starts at phase 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (rest) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + i_phase_delta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count        <= '0;
      r_top          <= RESET_TOP;
      o_duty         <= '0;
      muted          <= 1'b1;
      o_pwm          <= 1'b0;
      o_period_start <= 1'b0;
    end else begin
      r_count        <= count_next;
      o_period_start <= (count_next == '0);
      // Compares against the duty of the period now running; the value
      // loaded on the wrap clock takes effect from the next count 0.
      o_pwm          <= ~muted & (r_count < o_duty);
      if (wrap) begin
        r_top  <= new_top;
        o_duty <= duty_next;
        muted  <= rest;
      end
    end
  end

endmodule
